// File: rtl/execute_scheduler.sv
// execute_scheduler
//   Sequences the execute stage. It accepts one decoded op per issue handshake and
//   steps it through the ALU (one cycle) or the multiplier (MUL_LATENCY cycles, then
//   one writeback cycle, or two for a long multiply). It drives the stage's exec/cycle
//   strobes and the writeback enables. Decode is back-pressured while a multiply
//   occupies the stage.
//
// Parameters
//   MUL_LATENCY      cycles m_ma_cycle_o is held per multiply (1..15)
//
// Optional feature
//   EXEC_SCHED_PERF_EN  when defined, adds stall_count_o[31:0]. It counts cycles in
//                       which issue_valid_i=1 and issue_ready_o=0. It wraps, and
//                       flush does not clear it.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   issue_valid_i      decode presents an op
//   issue_ready_o      scheduler accepts an op this cycle (combinational)
//   op_class_i         00 nop, 01 data op, 10 MUL/MLA, 11 long multiply
//   dest_lo_i          destination (low word for long multiply)
//   dest_hi_i          high-word destination, long multiply only
//   set_flags_i        op updates CPSR
//   flush_i            squash current and incoming op
//   exec_o             execute-stage enable
//   do_cycle_o         data-operation cycle
//   m_ma_cycle_o       multiply / multiply-accumulate cycle
//   dest_o             destination for the current writeback
//   write_dest_do_o    write ALU result to dest_o
//   write_dest_m_o     write multiplier result word to dest_o
//   write_cpsr_o       write flags
//   hi_sel_o           select m_result[63:32] for this writeback
//   busy_o             scheduler is not idle
module execute_scheduler #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [1:0]  op_class_i,
    input  logic [3:0]  dest_lo_i,
    input  logic [3:0]  dest_hi_i,
    input  logic        set_flags_i,
    input  logic        flush_i,
    output logic        exec_o,
    output logic        do_cycle_o,
    output logic        m_ma_cycle_o,
    output logic [3:0]  dest_o,
    output logic        write_dest_do_o,
    output logic        write_dest_m_o,
    output logic        write_cpsr_o,
    output logic        hi_sel_o,
    output logic        busy_o
`ifdef EXEC_SCHED_PERF_EN
    ,
    output logic [31:0] stall_count_o
`endif
);

    typedef enum logic [2:0] {IDLE, ALU, MUL, WB_LO, WB_HI} state_t;

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

    state_t     state, state_next, target;
    logic [3:0] mul_count, mul_count_next;
    logic       accept;

    // Fields of the latched op
    logic       op_long_q, set_flags_q;
    logic [3:0] dest_lo_q, dest_hi_q;

    // Fields of the op that owns the next state: the newly accepted op if there is one,
    // otherwise the latched op
    logic       long_n, flags_n;
    logic [3:0] lo_n, hi_n;

    // Next values of the registered outputs
    logic       exec_n, do_cycle_n, m_ma_n, write_do_n, write_m_n, cpsr_n, hi_sel_n;
    logic [3:0] dest_n;

    // The stage accepts a new op in any state whose current cycle ends the occupying op.
    // The low-word writeback of a long multiply still has its high word to come.
    always_comb begin
        issue_ready_o = 1'b0;
        if (rst_n && !flush_i) begin
            case (state)
                IDLE, ALU, WB_HI: issue_ready_o = 1'b1;
                WB_LO:            issue_ready_o = !op_long_q;
                default:          issue_ready_o = 1'b0;
            endcase
        end
    end

    assign accept = issue_valid_i & issue_ready_o;
    assign busy_o = (state != IDLE);

    always_comb begin
        target = IDLE;
        case (op_class_i)
            2'b01:        target = ALU;
            2'b10, 2'b11: target = MUL;
            default:      target = IDLE;
        endcase
    end

    always_comb begin
        long_n  = accept ? (op_class_i == 2'b11) : op_long_q;
        flags_n = accept ? set_flags_i : set_flags_q;
        lo_n    = accept ? dest_lo_i : dest_lo_q;
        hi_n    = accept ? dest_hi_i : dest_hi_q;
    end

    // Next-state logic. A flush always returns to IDLE, which also drops any op
    // presented in the same cycle because flush forces issue_ready_o low.
    always_comb begin
        state_next     = state;
        mul_count_next = mul_count;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                MUL: begin
                    if (mul_count == 4'd0) begin
                        state_next = WB_LO;
                    end else begin
                        mul_count_next = mul_count - 4'd1;
                    end
                end
                WB_LO: begin
                    if (op_long_q) begin
                        state_next = WB_HI;
                    end else begin
                        state_next = accept ? target : IDLE;
                    end
                end
                default: begin
                    state_next = accept ? target : IDLE;
                end
            endcase
            if (accept && op_class_i[1]) begin
                mul_count_next = MUL_CNT_INIT;
            end
        end
    end

    // Output decode from the next state. The outputs are registered, so each value
    // appears in the cycle the state is entered.
    always_comb begin
        exec_n     = 1'b0;
        do_cycle_n = 1'b0;
        m_ma_n     = 1'b0;
        write_do_n = 1'b0;
        write_m_n  = 1'b0;
        cpsr_n     = 1'b0;
        hi_sel_n   = 1'b0;
        dest_n     = 4'd0;
        case (state_next)
            ALU: begin
                exec_n     = 1'b1;
                do_cycle_n = 1'b1;
                write_do_n = 1'b1;
                dest_n     = lo_n;
                cpsr_n     = flags_n;
            end
            MUL: begin
                exec_n = 1'b1;
                m_ma_n = 1'b1;
            end
            WB_LO: begin
                write_m_n = 1'b1;
                dest_n    = lo_n;
                cpsr_n    = flags_n & !long_n;
            end
            WB_HI: begin
                write_m_n = 1'b1;
                dest_n    = hi_n;
                hi_sel_n  = 1'b1;
                cpsr_n    = flags_n;
            end
            default: begin
                exec_n = 1'b0;
            end
        endcase
    end

    // State, multiply counter and latched op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mul_count   <= 4'd0;
            op_long_q   <= 1'b0;
            set_flags_q <= 1'b0;
            dest_lo_q   <= 4'd0;
            dest_hi_q   <= 4'd0;
        end else begin
            state     <= state_next;
            mul_count <= mul_count_next;
            if (accept) begin
                op_long_q   <= (op_class_i == 2'b11);
                set_flags_q <= set_flags_i;
                dest_lo_q   <= dest_lo_i;
                dest_hi_q   <= dest_hi_i;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_o          <= 1'b0;
            do_cycle_o      <= 1'b0;
            m_ma_cycle_o    <= 1'b0;
            dest_o          <= 4'd0;
            write_dest_do_o <= 1'b0;
            write_dest_m_o  <= 1'b0;
            write_cpsr_o    <= 1'b0;
            hi_sel_o        <= 1'b0;
        end else begin
            exec_o          <= exec_n;
            do_cycle_o      <= do_cycle_n;
            m_ma_cycle_o    <= m_ma_n;
            dest_o          <= dest_n;
            write_dest_do_o <= write_do_n;
            write_dest_m_o  <= write_m_n;
            write_cpsr_o    <= cpsr_n;
            hi_sel_o        <= hi_sel_n;
        end
    end

`ifdef EXEC_SCHED_PERF_EN
    // Stall counter. It wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_o <= 32'd0;
        end else if (issue_valid_i && !issue_ready_o) begin
            stall_count_o <= stall_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execute_scheduler.sv
// tb_execute_scheduler
//   Self-checking bench for execute_scheduler. It runs a directed vector table, a
//   hand-written reset-during-multiply sequence, and random traffic. The random traffic
//   is checked against a model that keeps a queue of the per-cycle outputs each op
//   will produce.
module tb_execute_scheduler;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [1:0] op_class = 2'b00;
    logic [3:0] dest_lo = 4'd0;
    logic [3:0] dest_hi = 4'd0;
    logic       set_flags = 1'b0;
    logic       flush = 1'b0;
    logic       exec, do_cycle, m_ma_cycle, write_do, write_m, write_cpsr, hi_sel, busy;
    logic [3:0] dest;
`ifdef EXEC_SCHED_PERF_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    execute_scheduler #(.MUL_LATENCY(L)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .op_class_i      (op_class),
        .dest_lo_i       (dest_lo),
        .dest_hi_i       (dest_hi),
        .set_flags_i     (set_flags),
        .flush_i         (flush),
        .exec_o          (exec),
        .do_cycle_o      (do_cycle),
        .m_ma_cycle_o    (m_ma_cycle),
        .dest_o          (dest),
        .write_dest_do_o (write_do),
        .write_dest_m_o  (write_m),
        .write_cpsr_o    (write_cpsr),
        .hi_sel_o        (hi_sel),
        .busy_o          (busy)
`ifdef EXEC_SCHED_PERF_EN
        ,
        .stall_count_o   (stall_count)
`endif
    );

    typedef struct packed {
        logic       exe;
        logic       doc;
        logic       mma;
        logic       wdo;
        logic       wm;
        logic       cps;
        logic       hs;
        logic [3:0] dst;
    } out_t;

    typedef struct {
        logic       v;
        logic [1:0] cls;
        logic [3:0] lo;
        logic [3:0] hi;
        logic       sf;
        logic       fl;
        logic       rdy;
        out_t       exp;
    } vec_t;

    int   passCount = 0;
    int   totalCount = 0;
    vec_t vecs[$];

    // Reference model: the outputs still owed by the op in flight, one entry per cycle
    out_t   modelQ[$];
    out_t   modelDisp;
    logic   modelReady;
    int     modelStalls;
    logic   sampledReady;

    function automatic out_t mk(logic exe, logic doc, logic mma, logic wdo, logic wm,
                                logic cps, logic hs, logic [3:0] dst);
        out_t o;
        o.exe = exe; o.doc = doc; o.mma = mma; o.wdo = wdo;
        o.wm = wm; o.cps = cps; o.hs = hs; o.dst = dst;
        return o;
    endfunction

    task automatic addVec(input logic v, input logic [1:0] cls, input logic [3:0] lo,
                          input logic [3:0] hi, input logic sf, input logic fl,
                          input logic rdy, input out_t exp);
        vec_t e;
        e.v = v; e.cls = cls; e.lo = lo; e.hi = hi; e.sf = sf; e.fl = fl;
        e.rdy = rdy; e.exp = exp;
        vecs.push_back(e);
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelDisp = '0;
        modelStalls = 0;
    endtask

    // One clock edge of the model. The stage takes a new op only when the op in flight
    // owes no further cycles after the current one.
    task automatic modelEdge(input logic v, input logic [1:0] cls, input logic [3:0] lo,
                             input logic [3:0] hi, input logic sf, input logic fl);
        if (v && !modelReady) modelStalls++;
        if (fl) begin
            modelQ.delete();
        end else if (v && modelReady) begin
            if (cls == 2'b01) begin
                modelQ.push_back(mk(1, 1, 0, 1, 0, sf, 0, lo));
            end else if (cls[1]) begin
                for (int i = 0; i < L; i++) modelQ.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'd0));
                modelQ.push_back(mk(0, 0, 0, 0, 1, (cls == 2'b10) ? sf : 1'b0, 0, lo));
                if (cls == 2'b11) modelQ.push_back(mk(0, 0, 0, 0, 1, sf, 1, hi));
            end
        end
        modelDisp = (modelQ.size() > 0) ? modelQ.pop_front() : out_t'('0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input out_t exp);
        checkOutput({tag, " exec"},     int'(exec),       int'(exp.exe));
        checkOutput({tag, " do_cycle"}, int'(do_cycle),   int'(exp.doc));
        checkOutput({tag, " m_ma"},     int'(m_ma_cycle), int'(exp.mma));
        checkOutput({tag, " wr_do"},    int'(write_do),   int'(exp.wdo));
        checkOutput({tag, " wr_m"},     int'(write_m),    int'(exp.wm));
        checkOutput({tag, " cpsr"},     int'(write_cpsr), int'(exp.cps));
        checkOutput({tag, " hi_sel"},   int'(hi_sel),     int'(exp.hs));
        checkOutput({tag, " dest"},     int'(dest),       int'(exp.dst));
        checkOutput({tag, " busy"},     int'(busy),       int'(exp.exe | exp.wm));
    endtask

    // Drive one cycle of inputs. Ready is sampled before the edge, and the model
    // steps on the edge. The task returns 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic [1:0] cls, input logic [3:0] lo,
                                 input logic [3:0] hi, input logic sf, input logic fl);
        @(negedge clk);
        issue_valid = v; op_class = cls; dest_lo = lo; dest_hi = hi;
        set_flags = sf; flush = fl;
        #1;
        sampledReady = issue_ready;
        modelReady = (modelQ.size() == 0) && !fl;
        @(posedge clk);
        modelEdge(v, cls, lo, hi, sf, fl);
        #1;
    endtask

    initial begin
        out_t z, mulc;
        z = '0;
        mulc = mk(1, 0, 1, 0, 0, 0, 0, 4'd0);

        // Three back-to-back data ops
        addVec(1, 2'b01, 4'd1, 4'd0, 0, 0, 1, mk(1, 1, 0, 1, 0, 0, 0, 4'd1));
        addVec(1, 2'b01, 4'd2, 4'd0, 0, 0, 1, mk(1, 1, 0, 1, 0, 0, 0, 4'd2));
        addVec(1, 2'b01, 4'd3, 4'd0, 1, 0, 1, mk(1, 1, 0, 1, 0, 1, 0, 4'd3));
        // MUL dest 5 with flags; its dest_hi is ignored
        addVec(1, 2'b10, 4'd5, 4'hF, 1, 0, 1, mulc);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mulc);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 0, 4'd5));
        // Long multiply lo=4 hi=7, accepted in the short multiply's writeback cycle
        addVec(1, 2'b11, 4'd4, 4'd7, 1, 0, 1, mulc);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mulc);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'd4));
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 1, 4'd7));
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 1, z);
        // Long multiply flushed in its low-word writeback; the data op with the flush is dropped
        addVec(1, 2'b11, 4'd9, 4'd10, 1, 0, 1, mulc);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mulc);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 4'd9));
        addVec(1, 2'b01, 4'd3, 4'd0, 1, 1, 0, z);
        addVec(1, 2'b01, 4'd6, 4'd0, 0, 0, 1, mk(1, 1, 0, 1, 0, 0, 0, 4'd6));
        // Nop, then flush together with valid in idle
        addVec(1, 2'b00, 4'd8, 4'd0, 1, 0, 1, z);
        addVec(1, 2'b01, 4'd2, 4'd0, 0, 1, 0, z);
        addVec(0, 2'b00, 4'd0, 4'd0, 0, 0, 1, z);

        modelReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", z);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready after reset", int'(issue_ready), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].cls, vecs[i].lo, vecs[i].hi, vecs[i].sf, vecs[i].fl);
            checkOutput($sformatf("vec%0d ready", i), int'(sampledReady), int'(vecs[i].rdy));
            checkAll($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset asserted in the middle of a multiply
        applyStimulus(1, 2'b10, 4'd5, 4'd0, 1, 0);
        checkOutput("pre-reset m_ma", int'(m_ma_cycle), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("async reset", z);
        @(negedge clk);
        issue_valid = 1'b0;
        rst_n = 1'b1;
        modelReset();
        #1;
        checkOutput("ready after mid-op reset", int'(issue_ready), 1);
        applyStimulus(1, 2'b01, 4'd3, 4'd0, 0, 0);
        checkAll("post-reset data", mk(1, 1, 0, 1, 0, 0, 0, 4'd3));
        applyStimulus(0, 2'b00, 4'd0, 4'd0, 0, 0);
        checkAll("post-reset idle", z);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic v, sf, fl;
            logic [1:0] cls;
            logic [3:0] lo, hi;
            v   = ($urandom_range(0, 9) < 7);
            cls = 2'($urandom_range(0, 3));
            lo  = 4'($urandom_range(0, 15));
            hi  = 4'($urandom_range(0, 15));
            sf  = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 19) == 0);
            applyStimulus(v, cls, lo, hi, sf, fl);
            checkOutput($sformatf("rand%0d ready", i), int'(sampledReady), int'(modelReady));
            checkAll($sformatf("rand%0d", i), modelDisp);
`ifdef EXEC_SCHED_PERF_EN
            checkOutput($sformatf("rand%0d stalls", i), int'(stall_count), modelStalls);
`endif
        end

`ifdef EXEC_SCHED_PERF_EN
        begin
            int startCount;
            applyStimulus(1, 2'b11, 4'd1, 4'd2, 0, 1);
            startCount = int'(stall_count);
            applyStimulus(1, 2'b11, 4'd1, 4'd2, 0, 0);
            for (int i = 0; i < L + 2; i++) applyStimulus(1, 2'b01, 4'd3, 4'd0, 0, 0);
            checkOutput("stall count long mul", int'(stall_count) - startCount, L + 1);
        end
`endif

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
